nn_output_argmax: RTL and testbench



---
 rtl/nn_pkg.sv | 12 +
 rtl/nn_sat_counter.sv | 15 +
 rtl/nn_output_argmax.sv | 133 +++++++++++++
 tb/tb_nn_output_argmax.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared constants and types for the perceptron classifier blocks.
package nn_pkg;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned N_NEURONS = 4;
  localparam int unsigned IDX_W     = $clog2(N_NEURONS);
  localparam int unsigned CNT_W     = 8;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  typedef logic [IDX_W-1:0] class_idx_t;

  localparam class_idx_t LAST_IDX = class_idx_t'(N_NEURONS - 1);
endpackage

// File: rtl/nn_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module nn_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk) begin
    if (reset || clear) count <= '0;
    else if (inc && (count != '1)) count <= count + 1'b1;
  end
endmodule

// File: rtl/nn_output_argmax.sv
// Sequential argmax over a snapshot of the four neuron outputs, with result
// handshake and per-class saturating win statistics.
module nn_output_argmax #(
  parameter int unsigned DATA_W    = nn_pkg::DATA_W,
  parameter int unsigned N_NEURONS = nn_pkg::N_NEURONS,
  parameter int unsigned MARGIN    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [DATA_W-1:0]       neuron0_output,
  input  logic [DATA_W-1:0]       neuron1_output,
  input  logic [DATA_W-1:0]       neuron2_output,
  input  logic [DATA_W-1:0]       neuron3_output,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [nn_pkg::IDX_W-1:0] class_idx,
  output logic [DATA_W-1:0]       class_value,
  output logic                    tie,
  output logic                    confident,
  output logic                    busy,
  input  logic                    clear_counts,
  input  logic [nn_pkg::IDX_W-1:0] count_sel,
  output logic [nn_pkg::CNT_W-1:0] count_out
);
  import nn_pkg::*;

  state_t            state, state_n;
  logic [DATA_W-1:0] snap [N_NEURONS];
  class_idx_t        scan_idx;
  logic [DATA_W-1:0] best, second, best_n, second_n, cur;
  class_idx_t        best_idx, best_idx_n;
  logic              tie_r, tie_n, conf_n, handshake;
  logic [DATA_W:0]   diff;
  logic [CNT_W-1:0]  counts [N_NEURONS];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    cur        = snap[scan_idx];
    best_n     = best;
    second_n   = second;
    best_idx_n = best_idx;
    tie_n      = tie_r;
    handshake  = 1'b0;
    if (scan_idx == '0) begin
      best_n     = cur;
      second_n   = '0;
      best_idx_n = '0;
      tie_n      = 1'b0;
    end else if (cur > best) begin
      second_n   = best;
      best_n     = cur;
      best_idx_n = scan_idx;
      tie_n      = 1'b0;
    end else if (cur == best) begin
      tie_n    = 1'b1;
      second_n = cur;
    end else if (cur > second) begin
      second_n = cur;
    end
    // best >= second always holds, so the widened difference never wraps
    diff   = {1'b0, best_n} - {1'b0, second_n};
    conf_n = !tie_n && (diff >= (DATA_W+1)'(MARGIN));
    case (state)
      IDLE: if (start) state_n = SCAN;
      SCAN: if (scan_idx == LAST_IDX) state_n = DONE;
      DONE: if (result_ready) begin
        state_n   = IDLE;
        handshake = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_valid <= 1'b0;
      busy         <= 1'b0;
      class_idx    <= '0;
      class_value  <= '0;
      tie          <= 1'b0;
      confident    <= 1'b0;
      best         <= '0;
      second       <= '0;
      best_idx     <= '0;
      tie_r        <= 1'b0;
      scan_idx     <= '0;
    end else begin
      result_valid <= (state_n == DONE);
      busy         <= (state_n != IDLE);
      if (state == IDLE && start) begin
        snap[0]  <= neuron0_output;
        snap[1]  <= neuron1_output;
        snap[2]  <= neuron2_output;
        snap[3]  <= neuron3_output;
        best     <= '0;
        second   <= '0;
        best_idx <= '0;
        tie_r    <= 1'b0;
        scan_idx <= '0;
      end else if (state == SCAN) begin
        best     <= best_n;
        second   <= second_n;
        best_idx <= best_idx_n;
        tie_r    <= tie_n;
        scan_idx <= class_idx_t'(scan_idx + 1'b1);
        if (scan_idx == LAST_IDX) begin
          class_idx   <= best_idx_n;
          class_value <= best_n;
          tie         <= tie_n;
          confident   <= conf_n;
        end
      end
    end
  end

  for (genvar i = 0; i < N_NEURONS; i++) begin : g_cnt
    nn_sat_counter #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (clear_counts),
      .inc   (handshake && (class_idx == class_idx_t'(i))),
      .count (counts[i])
    );
  end

  assign count_out = counts[count_sel];
endmodule

// File: tb/tb_nn_output_argmax.sv
// Self-checking bench for nn_output_argmax: spec vectors, random vectors
// against a sort-style reference model, and multi-cycle corner sequences.
module tb_nn_output_argmax;
  localparam int MARGIN = 16;

  typedef logic [7:0] vec_t [4];
  typedef struct {
    logic [7:0] v [4];
    logic [1:0] idx;
    logic [7:0] val;
    bit         t;
    bit         c;
  } vector_t;

  logic       clk = 0, reset = 1, start = 0, result_ready = 0, clear_counts = 0;
  logic [7:0] n0 = 0, n1 = 0, n2 = 0, n3 = 0;
  logic       result_valid, tie, confident, busy;
  logic [1:0] class_idx, count_sel = 0;
  logic [7:0] class_value, count_out;

  int errors = 0, checks = 0;
  int win [4];

  nn_output_argmax #(.DATA_W(8), .N_NEURONS(4), .MARGIN(MARGIN)) dut (
    .clk(clk), .reset(reset), .start(start),
    .neuron0_output(n0), .neuron1_output(n1), .neuron2_output(n2), .neuron3_output(n3),
    .result_valid(result_valid), .result_ready(result_ready),
    .class_idx(class_idx), .class_value(class_value), .tie(tie), .confident(confident),
    .busy(busy), .clear_counts(clear_counts), .count_sel(count_sel), .count_out(count_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: winner is the lowest-index maximum; runner-up is the second
  // element of the values sorted descending.
  function automatic void ref_model(input vec_t v, output logic [1:0] idx,
                                    output logic [7:0] val, output bit t, output bit c);
    int mx = -1, cnt = 0, sec = 0;
    idx = 0;
    for (int i = 0; i < 4; i++) if (int'(v[i]) > mx) begin mx = v[i]; idx = 2'(i); end
    for (int i = 0; i < 4; i++) if (int'(v[i]) == mx) cnt++;
    if (cnt > 1) sec = mx;
    else for (int i = 0; i < 4; i++) if (i != int'(idx) && int'(v[i]) > sec) sec = v[i];
    val = 8'(mx);
    t = (cnt > 1);
    c = !t && (mx - sec >= MARGIN);
  endfunction

  task automatic check_count(input string name, input int sel);
    count_sel = 2'(sel);
    #1;
    check(name, count_out, win[sel]);
  endtask

  // ready_delay 0: ready held high from start; otherwise ready stays low for
  // that many DONE cycles before being raised.
  task automatic classify(input vec_t v, input int ready_delay, input bit clr,
                          input logic [1:0] e_idx, input logic [7:0] e_val,
                          input bit e_tie, input bit e_conf);
    int n = 0;
    n0 = v[0]; n1 = v[1]; n2 = v[2]; n3 = v[3];
    start = 1;
    result_ready = (ready_delay == 0);
    tick();
    start = 0;
    check("busy_after_start", busy, 1);
    while (!result_valid && n < 20) begin tick(); n++; end
    check("latency", n, 4);
    check("class_idx", class_idx, e_idx);
    check("class_value", class_value, e_val);
    check("tie", tie, e_tie);
    check("confident", confident, e_conf);
    for (int k = 0; k < ready_delay; k++) begin
      tick();
      check("valid_held", result_valid, 1);
      check("idx_held", class_idx, e_idx);
    end
    result_ready = 1;
    clear_counts = clr;
    tick();
    clear_counts = 0;
    result_ready = 0;
    if (clr) for (int i = 0; i < 4; i++) win[i] = 0;
    else if (win[e_idx] < 255) win[e_idx]++;
    check("valid_drop", result_valid, 0);
    check("busy_drop", busy, 0);
    check_count("count_after_hs", e_idx);
  endtask

  vector_t tbl [8];

  initial begin
    vec_t v;
    logic [1:0] m_idx;
    logic [7:0] m_val;
    bit m_t, m_c;
    int n;

    tbl[0] = '{v:'{8'd10, 8'd200, 8'd50, 8'd30}, idx:2'd1, val:8'd200, t:0, c:1};
    tbl[1] = '{v:'{8'd90, 8'd90, 8'd20, 8'd0},   idx:2'd0, val:8'd90,  t:1, c:0};
    tbl[2] = '{v:'{8'd100, 8'd110, 8'd0, 8'd0},  idx:2'd1, val:8'd110, t:0, c:0};
    tbl[3] = '{v:'{8'd0, 8'd0, 8'd0, 8'd127},    idx:2'd3, val:8'd127, t:0, c:1};
    tbl[4] = '{v:'{8'd255, 8'd0, 8'd255, 8'd254},idx:2'd0, val:8'd255, t:1, c:0};
    tbl[5] = '{v:'{8'd16, 8'd0, 8'd0, 8'd0},     idx:2'd0, val:8'd16,  t:0, c:1};
    tbl[6] = '{v:'{8'd15, 8'd0, 8'd0, 8'd0},     idx:2'd0, val:8'd15,  t:0, c:0};
    tbl[7] = '{v:'{8'd0, 8'd0, 8'd0, 8'd0},      idx:2'd0, val:8'd0,   t:1, c:0};

    for (int i = 0; i < 4; i++) win[i] = 0;
    reset = 1;
    tick(); tick();
    reset = 0;
    check("rst_valid", result_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_tie", tie, 0);
    check("rst_conf", confident, 0);
    check("rst_idx", class_idx, 0);
    check("rst_value", class_value, 0);
    for (int i = 0; i < 4; i++) check_count("rst_count", i);

    for (int i = 0; i < 8; i++) classify(tbl[i].v, i % 3, 0, tbl[i].idx, tbl[i].val, tbl[i].t, tbl[i].c);

    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 4; i++) v[i] = (r % 2) ? 8'($urandom_range(0, 7) * 8) : 8'($urandom);
      ref_model(v, m_idx, m_val, m_t, m_c);
      classify(v, int'($urandom_range(0, 3)), 0, m_idx, m_val, m_t, m_c);
    end

    // input changes and start during SCAN; ready low for 5 DONE cycles
    n0 = 10; n1 = 20; n2 = 30; n3 = 40;
    start = 1; result_ready = 0;
    tick();
    n0 = 255; n1 = 255; n2 = 255; n3 = 255;
    n = 0;
    while (!result_valid && n < 20) begin
      check("busy_in_scan", busy, 1);
      tick(); n++;
    end
    check("snap_latency", n, 4);
    check("snap_idx", class_idx, 3);
    check("snap_value", class_value, 40);
    check("snap_conf", confident, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("hold_valid", result_valid, 1);
      check("hold_busy", busy, 1);
      check("hold_value", class_value, 40);
    end
    result_ready = 1;
    tick();
    result_ready = 0;
    win[3]++;
    check("start_at_hs_ignored", busy, 0);
    start = 0;
    tick();
    check("still_idle", busy, 0);
    check_count("count3_after_snap", 3);

    // saturation of class 2 wins
    v = '{8'd1, 8'd2, 8'd99, 8'd3};
    for (int k = 0; k < 300; k++) classify(v, 0, 0, 2'd2, 8'd99, 0, 1);
    count_sel = 2;
    #1;
    check("sat_count", count_out, 255);
    v = '{8'd5, 8'd60, 8'd1, 8'd2};
    classify(v, 0, 1, 2'd1, 8'd60, 0, 1);
    for (int i = 0; i < 4; i++) check_count("cleared", i);

    // reset during SCAN aborts, no counter update
    classify(v, 0, 0, 2'd1, 8'd60, 0, 1);
    n0 = 1; n1 = 2; n2 = 200; n3 = 3;
    start = 1;
    tick();
    start = 0;
    tick();
    reset = 1;
    tick();
    reset = 0;
    for (int i = 0; i < 4; i++) win[i] = 0;
    check("abort_busy", busy, 0);
    check("abort_valid", result_valid, 0);
    check("abort_idx", class_idx, 0);
    check("abort_value", class_value, 0);
    check("abort_conf", confident, 0);
    for (int i = 0; i < 4; i++) check_count("abort_count", i);
    v = '{8'd0, 8'd0, 8'd0, 8'd127};
    classify(v, 1, 0, 2'd3, 8'd127, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
